// File: rtl/vx_cache_core_req_bank_sel.sv
// Steers a batch of core request lanes to per-bank output stages, one lane per bank per cycle.
// Latency: 1 cycle from dispatch to per-bank valid. Same-bank lanes serialize in ascending lane order.
// Backpressure: a bank stage loads only when empty or draining. The batch is accepted once its last lane dispatches.
module vx_cache_core_req_bank_sel #(
  parameter  int NUM_BANKS        = 1,
  parameter  int WORD_SIZE        = 1,
  parameter  int NUM_REQS         = 1,
  parameter  int WORD_ADDR_WIDTH  = 32,
  parameter  int BANK_ADDR_OFFSET = 0,
  parameter  int CORE_TAG_WIDTH   = 1,
  localparam int WORD_WIDTH       = 8 * WORD_SIZE,
  localparam int REQS_BITS        = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                                             clk_i,
  input  logic                                             reset_i,
  // core side: one batch of NUM_REQS lanes sharing a tag
  input  logic [NUM_REQS-1:0]                              core_req_valid_i,
  input  logic [NUM_REQS-1:0]                              core_req_rw_i,
  input  logic [NUM_REQS-1:0][WORD_SIZE-1:0]               core_req_byteen_i,
  input  logic [NUM_REQS-1:0][WORD_ADDR_WIDTH-1:0]         core_req_addr_i,
  input  logic [NUM_REQS-1:0][WORD_WIDTH-1:0]              core_req_data_i,
  input  logic [CORE_TAG_WIDTH-1:0]                        core_req_tag_i,
  output logic                                             core_req_ready_o,
  // bank side: one registered request slot per bank
  output logic [NUM_BANKS-1:0]                             per_bank_core_req_valid_o,
  output logic [NUM_BANKS-1:0]                             per_bank_core_req_rw_o,
  output logic [NUM_BANKS-1:0][WORD_SIZE-1:0]              per_bank_core_req_byteen_o,
  output logic [NUM_BANKS-1:0][WORD_ADDR_WIDTH-1:0]        per_bank_core_req_addr_o,
  output logic [NUM_BANKS-1:0][WORD_WIDTH-1:0]             per_bank_core_req_data_o,
  output logic [NUM_BANKS-1:0][CORE_TAG_WIDTH-1:0]         per_bank_core_req_tag_o,
  output logic [NUM_BANKS-1:0][REQS_BITS-1:0]              per_bank_core_req_tid_o,
  input  logic [NUM_BANKS-1:0]                             per_bank_core_req_ready_i
);

  localparam int BANK_BITS = $clog2(NUM_BANKS);
  localparam int BSEL_W    = (BANK_BITS > 0) ? BANK_BITS : 1;

  // batch bookkeeping
  logic [NUM_REQS-1:0]               sent_mask_q, sent_mask_d;
  logic [NUM_REQS-1:0]               pending;
  logic [NUM_REQS-1:0]               dispatched;
  logic [NUM_REQS-1:0][BSEL_W-1:0]   lane_bank;

  // per-bank selection
  logic [NUM_BANKS-1:0]                 can_load;
  logic [NUM_BANKS-1:0]                 sel_vld;
  logic [NUM_BANKS-1:0]                 stage_load;
  logic [NUM_BANKS-1:0][REQS_BITS-1:0]  sel_tid;

  // per-bank output stage
  logic [NUM_BANKS-1:0]                       out_valid_q, out_valid_d;
  logic [NUM_BANKS-1:0]                       rw_q, rw_d;
  logic [NUM_BANKS-1:0][WORD_SIZE-1:0]        byteen_q, byteen_d;
  logic [NUM_BANKS-1:0][WORD_ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [NUM_BANKS-1:0][WORD_WIDTH-1:0]       data_q, data_d;
  logic [NUM_BANKS-1:0][CORE_TAG_WIDTH-1:0]   tag_q, tag_d;
  logic [NUM_BANKS-1:0][REQS_BITS-1:0]        tid_q, tid_d;

  // bank index of each lane; a single bank needs no address bits
  if (NUM_BANKS == 1) begin : g_one_bank
    assign lane_bank = '0;
  end else begin : g_multi_bank
    for (genvar i = 0; i < NUM_REQS; i++) begin : g_lane
      assign lane_bank[i] = core_req_addr_i[i][BANK_ADDR_OFFSET +: BANK_BITS];
    end
  end

  assign pending  = core_req_valid_i & ~sent_mask_q;
  assign can_load = ~out_valid_q | per_bank_core_req_ready_i;

  // pick the lowest-index pending lane per bank (descending scan, last hit wins)
  always_comb begin
    sel_vld = '0;
    sel_tid = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int i = NUM_REQS - 1; i >= 0; i--) begin
        if (pending[i] && (lane_bank[i] == BSEL_W'(b))) begin
          sel_vld[b] = 1'b1;
          sel_tid[b] = REQS_BITS'(i);
        end
      end
    end
  end

  assign stage_load = sel_vld & can_load;

  // mark winning lanes as dispatched and mux their payload toward the bank stage
  always_comb begin
    dispatched = '0;
    rw_d       = '0;
    byteen_d   = '0;
    addr_d     = '0;
    data_d     = '0;
    tag_d      = '0;
    tid_d      = sel_tid;
    for (int b = 0; b < NUM_BANKS; b++) begin
      tag_d[b] = core_req_tag_i;
      for (int i = 0; i < NUM_REQS; i++) begin
        if (sel_tid[b] == REQS_BITS'(i)) begin
          rw_d[b]     = core_req_rw_i[i];
          byteen_d[b] = core_req_byteen_i[i];
          addr_d[b]   = core_req_addr_i[i];
          data_d[b]   = core_req_data_i[i];
          if (stage_load[b]) begin
            dispatched[i] = 1'b1;
          end
        end
      end
    end
  end

  // batch completes when nothing pending is left behind this cycle
  assign core_req_ready_o = ~reset_i & (|core_req_valid_i) & ((pending & ~dispatched) == '0);

  // completed batch restarts the mask; otherwise remember what already left
  assign sent_mask_d = core_req_ready_o ? '0 : (sent_mask_q | dispatched);

  // a stage stays full unless drained without refill
  assign out_valid_d = stage_load | (out_valid_q & ~per_bank_core_req_ready_i);

  // control state: sent mask and stage valids
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sent_mask_q <= '0;
      out_valid_q <= '0;
    end else begin
      sent_mask_q <= sent_mask_d;
      out_valid_q <= out_valid_d;
    end
  end

  // payload registers load only with a dispatch; contents while empty are irrelevant
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (stage_load[b]) begin
        rw_q[b]     <= rw_d[b];
        byteen_q[b] <= byteen_d[b];
        addr_q[b]   <= addr_d[b];
        data_q[b]   <= data_d[b];
        tag_q[b]    <= tag_d[b];
        tid_q[b]    <= tid_d[b];
      end
    end
  end

  assign per_bank_core_req_valid_o  = out_valid_q & {NUM_BANKS{~reset_i}};
  assign per_bank_core_req_rw_o     = rw_q;
  assign per_bank_core_req_byteen_o = byteen_q;
  assign per_bank_core_req_addr_o   = addr_q;
  assign per_bank_core_req_data_o   = data_q;
  assign per_bank_core_req_tag_o    = tag_q;
  assign per_bank_core_req_tid_o    = tid_q;

endmodule
